// File: rtl/cpu_pkg.sv
// Shared CPU package: datapath widths and the decoded-control bundle that the
// decoder hands to the next-PC control stage.
package cpu_pkg;
  localparam int PC_W   = 8;  // program counter / branch target width
  localparam int LUT_AW = 5;  // branch-target LUT index width

  typedef struct packed {
    logic              op_branch;
    logic              op_call;
    logic              op_ret;
    logic              op_halt;
    logic [LUT_AW-1:0] lut_idx;
  } ctrl_t;
endpackage

// File: rtl/ret_stack.sv
// Return-address stack: DEPTH-entry LIFO of PC_W-bit addresses.
// Ports: CLK, Reset (sync, active-high), push/pop/din in; top, full, empty,
// depth out. top reads 0 when empty. The caller never asserts push and pop
// together, and never pushes when full or pops when empty.
module ret_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PC_W-1:0]          din,
  output logic [PC_W-1:0]          top,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   depth
);
  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0] mem_d [DEPTH];
  logic [AW:0]     depth_q, depth_d;
  logic [AW-1:0]   top_idx;

  // Low bits of depth minus one wrap correctly when full (DEPTH is 2^AW).
  assign top_idx = depth_q[AW-1:0] - AW'(1);
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == (AW+1)'(DEPTH));
  assign depth   = depth_q;
  assign top     = empty ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      mem_d[depth_q[AW-1:0]] = din;
      depth_d = depth_q + 1'b1;
    end else if (pop && !empty) begin
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      mem_q   <= '{default: '0};
      depth_q <= '0;
    end else begin
      mem_q   <= mem_d;
      depth_q <= depth_d;
    end
  end
endmodule

// File: rtl/branch_ctrl.sv
// Next-PC control stage. Turns the decoded op of the current instruction into
// the counter's branch / branch_adr / Halt inputs. Holds the software-loaded
// branch-target LUT, the sticky halt latch and the op priority mux; the
// return-address stack is a ret_stack instance.
// Ports: CLK, Reset (sync, active-high); PC, op_*, cond, lut_idx decoded
// inputs; lut_we/lut_waddr/lut_wdata LUT write port; branch, branch_adr,
// Halt (combinational) and stk_depth, err_ovf, err_unf (state) outputs.
module branch_ctrl
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LUT_N = 32
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [PC_W-1:0]            PC,
  input  logic                       op_branch,
  input  logic                       op_call,
  input  logic                       op_ret,
  input  logic                       op_halt,
  input  logic                       cond,
  input  logic [$clog2(LUT_N)-1:0]   lut_idx,
  input  logic                       lut_we,
  input  logic [$clog2(LUT_N)-1:0]   lut_waddr,
  input  logic [PC_W-1:0]            lut_wdata,
  output logic                       branch,
  output logic [PC_W-1:0]            branch_adr,
  output logic                       Halt,
  output logic [$clog2(DEPTH):0]     stk_depth,
  output logic                       err_ovf,
  output logic                       err_unf
);
  ctrl_t ctrl;

  logic [PC_W-1:0] lut_q [LUT_N];
  logic [PC_W-1:0] lut_d [LUT_N];
  logic            halt_q, halt_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_unf_q, err_unf_d;

  logic            win_ret, win_call, win_br;
  logic            push, pop;
  logic [PC_W-1:0] top, lut_rd;
  logic            full, empty;

  always_comb begin
    ctrl           = '0;
    ctrl.op_branch = op_branch;
    ctrl.op_call   = op_call;
    ctrl.op_ret    = op_ret;
    ctrl.op_halt   = op_halt;
    ctrl.lut_idx   = lut_idx;
  end

  assign Halt   = ctrl.op_halt | halt_q;
  // Async read sees the pre-edge contents, so a same-cycle write is invisible.
  assign lut_rd = lut_q[ctrl.lut_idx];

  // Priority halt > ret > call > branch; a halted stage has no winner at all.
  assign win_ret  = !Halt && ctrl.op_ret;
  assign win_call = !Halt && !ctrl.op_ret && ctrl.op_call;
  assign win_br   = !Halt && !ctrl.op_ret && !ctrl.op_call && ctrl.op_branch;

  assign push = win_call && !full;
  assign pop  = win_ret && !empty;

  always_comb begin
    branch     = 1'b0;
    branch_adr = '0;
    if (win_ret) begin
      if (!empty) begin
        branch     = 1'b1;
        branch_adr = top;
      end
    end else if (win_call || (win_br && cond)) begin
      // A call on a full stack still redirects; only the push is dropped.
      branch     = 1'b1;
      branch_adr = lut_rd;
    end
  end

  always_comb begin
    halt_d    = halt_q | ctrl.op_halt;
    err_ovf_d = err_ovf_q | (win_call && full);
    err_unf_d = err_unf_q | (win_ret && empty);
    lut_d     = lut_q;
    // LUT writes land even while halted.
    if (lut_we) lut_d[lut_waddr] = lut_wdata;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      halt_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      lut_q     <= '{default: '0};
    end else begin
      halt_q    <= halt_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      lut_q     <= lut_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

  // Return address is PC+1, wrapping at the top of the address space.
  ret_stack #(.DEPTH(DEPTH)) u_stk (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .din   (PC + PC_W'(1)),
    .top   (top),
    .full  (full),
    .empty (empty),
    .depth (stk_depth)
  );
endmodule
